// File: rtl/sequence_flasher_if.sv
// Bundle between the level logic and the sequence flasher.
// master drives button/enable/length/index; slave is the flasher.
interface sequence_flasher_if;
  logic       rng_button;
  logic       enable;
  logic [3:0] seq_len;
  logic [2:0] rd_idx;
  logic [3:0] rd_digit;
  logic [3:0] flash_num;
  logic       flash_valid;
  logic       busy;
  logic       seq_done;
  logic [3:0] seq_count;

  modport master (
    output rng_button, enable, seq_len, rd_idx,
    input  rd_digit, flash_num, flash_valid,
    input  busy, seq_done, seq_count
  );

  modport slave (
    input  rng_button, enable, seq_len, rd_idx,
    output rd_digit, flash_num, flash_valid,
    output busy, seq_done, seq_count
  );
endinterface

// File: rtl/sequence_flasher.sv
// Draws a random digit run from an LFSR, flashes it digit by digit,
// then holds it readable by index for answer checking.
module sequence_flasher #(
  parameter int unsigned FLASH_CYCLES = 8,
  parameter int unsigned GAP_CYCLES   = 2,
  parameter int unsigned MAX_LEN      = 8,
  parameter logic [15:0] SEED         = 16'hACE1
) (
  input logic              clock,
  input logic              rst,
  sequence_flasher_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE, GEN, FLASH, GAP, DONE
  } state_t;

  localparam logic [7:0] FL_LAST = 8'(FLASH_CYCLES - 1);
  localparam logic [7:0] GP_LAST = 8'(GAP_CYCLES - 1);
  localparam logic [3:0] LEN_MAX = 4'(MAX_LEN);

  state_t     state_q, state_d;
  logic [15:0] lfsr_q, lfsr_d;
  logic       sync1_q, sync1_d;
  logic       sync2_q, sync2_d;
  logic       hist_q, hist_d;
  logic [2:0] idx_q, idx_d;
  logic [7:0] cnt_q, cnt_d;
  logic [3:0] eff_len_q, eff_len_d;
  logic [3:0] mem_q [MAX_LEN];
  logic [3:0] mem_d [MAX_LEN];
  logic       flash_valid_q, flash_valid_d;
  logic [3:0] flash_num_q, flash_num_d;
  logic       busy_q, busy_d;
  logic       seq_done_q, seq_done_d;
  logic       press;
  logic       last;

  // Next-state, storage write and registered-output computation
  always_comb begin
    lfsr_d   = (lfsr_q >> 1) ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
    sync1_d  = bus.rng_button;
    sync2_d  = sync1_q;
    hist_d   = sync2_q;
    press    = hist_q & ~sync2_q;
    last     = ({1'b0, idx_q} == (eff_len_q - 4'd1));
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    eff_len_d = eff_len_q;
    mem_d    = mem_q;

    unique case (state_q)
      IDLE: begin
        if (press && bus.enable) begin
          state_d = GEN;
          idx_d   = 3'd0;
          cnt_d   = 8'd0;
          if (bus.seq_len == 4'd0)
            eff_len_d = 4'd1;
          else if (bus.seq_len > LEN_MAX)
            eff_len_d = LEN_MAX;
          else
            eff_len_d = bus.seq_len;
        end
      end
      GEN: begin
        mem_d[idx_q] = lfsr_q[3:0];
        if (last) begin
          state_d = FLASH;
          idx_d   = 3'd0;
          cnt_d   = 8'd0;
        end else begin
          idx_d = idx_q + 3'd1;
        end
      end
      FLASH: begin
        if (cnt_q == FL_LAST) begin
          cnt_d = 8'd0;
          if (GAP_CYCLES == 0) begin
            if (last) state_d = DONE;
            else      idx_d   = idx_q + 3'd1;
          end else begin
            state_d = GAP;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      GAP: begin
        if (cnt_q == GP_LAST) begin
          cnt_d = 8'd0;
          if (last) begin
            state_d = DONE;
          end else begin
            state_d = FLASH;
            idx_d   = idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (state_q != IDLE && !bus.enable)
      state_d = IDLE;

    busy_d        = (state_d != IDLE);
    flash_valid_d = (state_d == FLASH);
    flash_num_d   = flash_valid_d ? mem_d[idx_d] : 4'd0;
    seq_done_d    = (state_d == DONE);
  end

  // State, storage and output registers
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      lfsr_q        <= SEED;
      sync1_q       <= 1'b1;
      sync2_q       <= 1'b1;
      hist_q        <= 1'b1;
      idx_q         <= 3'd0;
      cnt_q         <= 8'd0;
      eff_len_q     <= 4'd0;
      flash_valid_q <= 1'b0;
      flash_num_q   <= 4'd0;
      busy_q        <= 1'b0;
      seq_done_q    <= 1'b0;
      for (int i = 0; i < MAX_LEN; i++)
        mem_q[i] <= 4'd0;
    end else begin
      state_q       <= state_d;
      lfsr_q        <= lfsr_d;
      sync1_q       <= sync1_d;
      sync2_q       <= sync2_d;
      hist_q        <= hist_d;
      idx_q         <= idx_d;
      cnt_q         <= cnt_d;
      eff_len_q     <= eff_len_d;
      flash_valid_q <= flash_valid_d;
      flash_num_q   <= flash_num_d;
      busy_q        <= busy_d;
      seq_done_q    <= seq_done_d;
      mem_q         <= mem_d;
    end
  end

  assign bus.rd_digit    = mem_q[bus.rd_idx];
  assign bus.flash_num   = flash_num_q;
  assign bus.flash_valid = flash_valid_q;
  assign bus.busy        = busy_q;
  assign bus.seq_done    = seq_done_q;
  assign bus.seq_count   = eff_len_q;

endmodule

// File: tb/tb_sequence_flasher.sv
// Directed bench for sequence_flasher with a digit scoreboard
// fed from an independent LFSR model.
module tb_sequence_flasher;

  logic clock = 1'b0;
  logic rst   = 1'b0;
  always #5 clock = ~clock;

  sequence_flasher_if bus();

  sequence_flasher dut (
    .clock (clock),
    .rst   (rst),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;
  int cyc;
  logic [3:0] exp_q[$];
  logic [3:0] exp_mem[8];

  // Edges seen since reset release; the DUT LFSR steps on each.
  always @(posedge clock or negedge rst) begin
    if (!rst) cyc <= 0;
    else      cyc <= cyc + 1;
  end

  function automatic logic [15:0] lfsr_at(int n);
    logic [15:0] v;
    v = 16'hACE1;
    for (int i = 0; i < n; i++)
      v = (v >> 1) ^ (v[0] ? 16'hB400 : 16'h0000);
    return v;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Press at the next negedge for two edges; GEN starts two edges later.
  task automatic press(int len);
    logic [15:0] v;
    @(negedge clock);
    exp_q.delete();
    for (int i = 0; i < len; i++) begin
      v = lfsr_at(cyc + 3 + i);
      exp_q.push_back(v[3:0]);
      exp_mem[i] = v[3:0];
    end
    bus.rng_button = 1'b0;
    @(negedge clock);
    @(negedge clock);
    bus.rng_button = 1'b1;
  endtask

  task automatic run_seq(input logic [3:0] len, input int l,
                         input int exp_busy, input int pr2_at,
                         input string tag);
    int busy_cnt, done_cnt, done_at, wins;
    int win_len, gap_len, bad, j;
    logic seen, fv_prev;
    logic [3:0] cur;
    busy_cnt = 0; done_cnt = 0; done_at = -1; wins = 0;
    win_len = 0; gap_len = 0; bad = 0; j = 0;
    seen = 1'b0; fv_prev = 1'b0; cur = 4'd0;
    bus.enable  = 1'b1;
    bus.seq_len = len;
    press(l);
    while (1) begin
      @(posedge clock); #1;
      if (pr2_at >= 0 && j == pr2_at)     bus.rng_button = 1'b0;
      if (pr2_at >= 0 && j == pr2_at + 2) bus.rng_button = 1'b1;
      if (bus.busy) begin busy_cnt++; seen = 1'b1; end
      if (bus.seq_done) begin done_cnt++; done_at = busy_cnt; end
      if (bus.flash_valid && !fv_prev) begin
        wins++;
        if (wins > 1) chk({tag, "_gap"}, gap_len, 2);
        if (exp_q.size() > 0) begin
          cur = exp_q.pop_front();
          chk({tag, "_digit"}, bus.flash_num, cur);
        end else begin
          chk({tag, "_extra_window"}, wins, l);
        end
        win_len = 0;
      end
      if (bus.flash_valid) begin
        win_len++;
        if (bus.flash_num !== cur) bad++;
      end else begin
        if (bus.flash_num !== 4'd0) bad++;
        if (fv_prev) begin
          chk({tag, "_win_len"}, win_len, 8);
          gap_len = 0;
        end
        gap_len++;
      end
      fv_prev = bus.flash_valid;
      j++;
      if (seen && !bus.busy) break;
      if (j > 400) begin
        chk({tag, "_timeout"}, j, 0);
        break;
      end
    end
    chk({tag, "_busy_len"}, busy_cnt, exp_busy);
    chk({tag, "_done_cnt"}, done_cnt, 1);
    chk({tag, "_done_last"}, done_at, exp_busy);
    chk({tag, "_windows"}, wins, l);
    chk({tag, "_num_bad"}, bad, 0);
    chk({tag, "_seq_count"}, bus.seq_count, l);
    for (int i = 0; i < l; i++) begin
      bus.rd_idx = 3'(i);
      #1;
      chk({tag, "_rd"}, bus.rd_digit, exp_mem[i]);
    end
    bus.rd_idx = 3'd0;
    repeat (3) @(posedge clock);
  endtask

  initial begin
    int wins, n, acc;
    logic fv_prev;
    bus.rng_button = 1'b1;
    bus.enable     = 1'b0;
    bus.seq_len    = 4'd0;
    bus.rd_idx     = 3'd0;

    // reset state
    repeat (2) @(posedge clock);
    #1;
    chk("rst_busy", bus.busy, 0);
    chk("rst_fv", bus.flash_valid, 0);
    chk("rst_num", bus.flash_num, 0);
    chk("rst_done", bus.seq_done, 0);
    chk("rst_count", bus.seq_count, 0);
    chk("rst_rd", bus.rd_digit, 0);
    @(negedge clock);
    rst = 1'b1;
    @(posedge clock); #1;
    chk("lfsr_step", dut.lfsr_q, 16'hE270);
    repeat (3) @(posedge clock);

    // level-1 flow and clamps
    run_seq(4'd3, 3, 34, -1, "l3");
    run_seq(4'd0, 1, 12, -1, "clamp0");
    run_seq(4'd12, 8, 89, -1, "clamp12");

    // press during FLASH is ignored
    run_seq(4'd3, 3, 34, 8, "press2");

    // abort in second flash window
    bus.enable  = 1'b1;
    bus.seq_len = 4'd3;
    press(3);
    wins = 0; fv_prev = 1'b0; n = 0;
    while (wins < 2 && n < 200) begin
      @(posedge clock); #1;
      if (bus.flash_valid && !fv_prev) wins++;
      fv_prev = bus.flash_valid;
      n++;
    end
    chk("abort_reach", wins, 2);
    bus.enable = 1'b0;
    @(posedge clock); #1;
    chk("abort_fv", bus.flash_valid, 0);
    chk("abort_busy", bus.busy, 0);
    chk("abort_num", bus.flash_num, 0);
    acc = 0;
    repeat (40) begin
      @(posedge clock); #1;
      if (bus.seq_done) acc++;
    end
    chk("abort_no_done", acc, 0);
    press(3);
    acc = 0;
    repeat (12) begin
      @(posedge clock); #1;
      if (bus.busy) acc++;
    end
    chk("dis_no_start", acc, 0);
    exp_q.delete();

    // async reset in the first gap
    bus.enable  = 1'b1;
    bus.seq_len = 4'd2;
    press(2);
    wins = 0; fv_prev = 1'b0; n = 0;
    while (!(wins == 1 && !bus.flash_valid) && n < 200) begin
      @(posedge clock); #1;
      if (bus.flash_valid && !fv_prev) wins++;
      fv_prev = bus.flash_valid;
      n++;
    end
    chk("gap_reach", wins, 1);
    #1;
    rst = 1'b0;
    #1;
    chk("arst_busy", bus.busy, 0);
    chk("arst_fv", bus.flash_valid, 0);
    chk("arst_num", bus.flash_num, 0);
    chk("arst_count", bus.seq_count, 0);
    chk("arst_rd", bus.rd_digit, 0);
    repeat (2) @(negedge clock);
    rst = 1'b1;
    exp_q.delete();
    repeat (2) @(posedge clock);
    run_seq(4'd2, 2, 23, -1, "regen");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
